// File: rtl/p3_execute_pkg.sv
// Shared encodings for the execute stage: opcodes, instruction classes,
// memwrite codes and flag bit positions.
package p3_execute_pkg;

  localparam int DATA_W  = 16;
  localparam int SHAMT_W = 4;

  localparam logic [1:0] CLS_0   = 2'd0;
  localparam logic [1:0] CLS_1   = 2'd1;
  localparam logic [1:0] CLS_2   = 2'd2;
  localparam logic [1:0] CLS_ALU = 2'd3;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SLR = 4'd9;
  localparam logic [3:0] OP_SRL = 4'd10;
  localparam logic [3:0] OP_SRA = 4'd11;
  localparam logic [3:0] OP_HLT = 4'd15;

  localparam logic [1:0] MW_NONE  = 2'b00;
  localparam logic [1:0] MW_LOAD  = 2'b01;
  localparam logic [1:0] MW_STORE = 2'b10;

  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic is_shift_op(input logic [3:0] op);
    logic r;
    r = (op == OP_SLL) || (op == OP_SLR) || (op == OP_SRL) || (op == OP_SRA);
    return r;
  endfunction

endpackage

// File: rtl/p3_execute_if.sv
// Decode-to-execute and execute-to-memory handshake bundle.
// master = upstream/downstream environment, slave = the execute stage.
interface p3_execute_if #(parameter int WIDTH = 16, parameter int SHAMT_W = 4);

  logic               in_valid;
  logic               in_ready;
  logic [1:0]         op_class;
  logic [3:0]         opcode;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu1;
  logic [WIDTH-1:0]   alu2;
  logic               writereg;
  logic [1:0]         memwrite;
  logic [2:0]         regaddress;
  logic [WIDTH-1:0]   address;
  logic [WIDTH-1:0]   storedata;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               ex_writereg;
  logic [1:0]         ex_memwrite;
  logic [2:0]         ex_regaddress;
  logic [WIDTH-1:0]   ex_address;
  logic [WIDTH-1:0]   ex_storedata;
  logic [3:0]         flags;
  logic               halted;

  modport master (
    output in_valid, op_class, opcode, shamt, alu1, alu2, writereg, memwrite,
           regaddress, address, storedata, out_ready,
    input  in_ready, out_valid, result, ex_writereg, ex_memwrite, ex_regaddress,
           ex_address, ex_storedata, flags, halted
  );

  modport slave (
    input  in_valid, op_class, opcode, shamt, alu1, alu2, writereg, memwrite,
           regaddress, address, storedata, out_ready,
    output in_ready, out_valid, result, ex_writereg, ex_memwrite, ex_regaddress,
           ex_address, ex_storedata, flags, halted
  );

endinterface

// File: rtl/p3_execute_alu.sv
// Combinational ALU, barrel shifter and SZCV flag computation for p3_execute.
module p3_alu
  import p3_execute_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic [1:0]         op_class_i,
  input  logic [3:0]         opcode_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [WIDTH-1:0]   address_i,
  input  logic [3:0]         flags_i,
  output logic [WIDTH-1:0]   result_o,
  output logic [3:0]         flags_o,
  output logic               nowrite_o,
  output logic               hlt_o
);

  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [2*WIDTH-1:0] wide_s;
  logic [WIDTH-1:0]   res_s;
  logic               carry_s;
  logic               ovf_s;
  logic               upd_s;

  assign sum_s  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_s = {1'b0, a_i} - {1'b0, b_i};

  // Double-width shift so the last bit out lands at a fixed position
  always_comb begin
    wide_s = {(2*WIDTH){1'b0}};
    case (opcode_i)
      OP_SLL:  wide_s = {{WIDTH{1'b0}}, a_i} << shamt_i;
      OP_SLR:  wide_s = {a_i, a_i} << shamt_i;
      OP_SRL:  wide_s = {a_i, {WIDTH{1'b0}}} >> shamt_i;
      OP_SRA:  wide_s = $signed({a_i, {WIDTH{1'b0}}}) >>> shamt_i;
      default: wide_s = {(2*WIDTH){1'b0}};
    endcase
  end

  // Operation decode and result/carry/overflow select
  always_comb begin
    res_s     = {WIDTH{1'b0}};
    carry_s   = 1'b0;
    ovf_s     = 1'b0;
    upd_s     = 1'b0;
    nowrite_o = 1'b0;
    hlt_o     = 1'b0;
    if (op_class_i == CLS_ALU) begin
      case (opcode_i)
        OP_ADD: begin
          res_s   = sum_s[WIDTH-1:0];
          carry_s = sum_s[WIDTH];
          ovf_s   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_s[WIDTH-1] != a_i[WIDTH-1]);
          upd_s   = 1'b1;
        end
        OP_SUB, OP_CMP: begin
          res_s     = diff_s[WIDTH-1:0];
          carry_s   = diff_s[WIDTH];
          ovf_s     = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff_s[WIDTH-1] != a_i[WIDTH-1]);
          upd_s     = 1'b1;
          nowrite_o = (opcode_i == OP_CMP);
        end
        OP_AND: begin res_s = a_i & b_i; upd_s = 1'b1; end
        OP_OR:  begin res_s = a_i | b_i; upd_s = 1'b1; end
        OP_XOR: begin res_s = a_i ^ b_i; upd_s = 1'b1; end
        OP_MOV: begin res_s = b_i;       upd_s = 1'b1; end
        OP_SLL: begin
          res_s   = wide_s[WIDTH-1:0];
          carry_s = wide_s[WIDTH];
          upd_s   = 1'b1;
        end
        OP_SLR: begin
          res_s   = wide_s[2*WIDTH-1:WIDTH];
          carry_s = (shamt_i != {SHAMT_W{1'b0}}) && wide_s[WIDTH];
          upd_s   = 1'b1;
        end
        OP_SRL, OP_SRA: begin
          res_s   = wide_s[2*WIDTH-1:WIDTH];
          carry_s = wide_s[WIDTH-1];
          upd_s   = 1'b1;
        end
        OP_HLT: hlt_o = 1'b1;
        default: nowrite_o = 1'b1;
      endcase
    end else begin
      res_s = address_i;
    end
  end

  assign result_o = res_s;
  assign flags_o  = upd_s ? {res_s[WIDTH-1], (res_s == {WIDTH{1'b0}}), carry_s, ovf_s} : flags_i;

endmodule

// File: rtl/p3_execute.sv
// SIMPLE pipeline execute stage: handshake, FSM and output/flag registers.
// Define P3_SERIAL_SHIFT_EN for a 1-bit-per-cycle shifter instead of the barrel.
module p3_execute
  import p3_execute_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input logic         clock,
  input logic         reset_n,
  p3_execute_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
`ifdef P3_SERIAL_SHIFT_EN
  localparam logic [1:0] ST_SHIFT = 2'd1;
`endif
  localparam logic [1:0] ST_HALT  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ex_writereg_q, ex_writereg_d;
  logic [1:0]       ex_memwrite_q, ex_memwrite_d;
  logic [2:0]       ex_regaddress_q, ex_regaddress_d;
  logic [WIDTH-1:0] ex_address_q, ex_address_d;
  logic [WIDTH-1:0] ex_storedata_q, ex_storedata_d;
  logic [3:0]       flags_q, flags_d;
  logic             halted_q, halted_d;

  logic             in_ready_s;
  logic             accept_s;
  logic             out_free_s;
  logic [WIDTH-1:0] alu_result_s;
  logic [3:0]       alu_flags_s;
  logic             alu_nowrite_s;
  logic             alu_hlt_s;

`ifdef P3_SERIAL_SHIFT_EN
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic               p_writereg_q, p_writereg_d;
  logic [1:0]         p_memwrite_q, p_memwrite_d;
  logic [2:0]         p_regaddress_q, p_regaddress_d;
  logic [WIDTH-1:0]   p_address_q, p_address_d;
  logic [WIDTH-1:0]   p_storedata_q, p_storedata_d;
  logic [WIDTH:0]     step_s;
  logic               start_serial_s;

  // One-bit step of the serial shifter; MSB of the return is the bit shifted out
  function automatic logic [WIDTH:0] shift_step(input logic [3:0] op, input logic [WIDTH-1:0] v);
    logic [WIDTH:0] r;
    case (op)
      OP_SLL:  r = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
      OP_SLR:  r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      OP_SRL:  r = {v[0], 1'b0, v[WIDTH-1:1]};
      OP_SRA:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      default: r = {1'b0, v};
    endcase
    return r;
  endfunction

  assign step_s         = shift_step(op_q, sh_q);
  assign start_serial_s = (bus.op_class == CLS_ALU) && is_shift_op(bus.opcode)
                          && (bus.shamt != {SHAMT_W{1'b0}});
`endif

  p3_alu #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_alu (
    .op_class_i (bus.op_class),
    .opcode_i   (bus.opcode),
    .shamt_i    (bus.shamt),
    .a_i        (bus.alu2),
    .b_i        (bus.alu1),
    .address_i  (bus.address),
    .flags_i    (flags_q),
    .result_o   (alu_result_s),
    .flags_o    (alu_flags_s),
    .nowrite_o  (alu_nowrite_s),
    .hlt_o      (alu_hlt_s)
  );

  assign out_free_s = ~out_valid_q | bus.out_ready;
  assign in_ready_s = (state_q == ST_IDLE) && out_free_s;
  assign accept_s   = bus.in_valid && in_ready_s;

  // Next-state: accept, serial shift progress, output hold under back-pressure
  always_comb begin
    state_d         = state_q;
    out_valid_d     = out_valid_q & ~bus.out_ready;
    result_d        = result_q;
    ex_writereg_d   = ex_writereg_q;
    ex_memwrite_d   = ex_memwrite_q;
    ex_regaddress_d = ex_regaddress_q;
    ex_address_d    = ex_address_q;
    ex_storedata_d  = ex_storedata_q;
    flags_d         = flags_q;
    halted_d        = halted_q;
`ifdef P3_SERIAL_SHIFT_EN
    sh_d            = sh_q;
    cnt_d           = cnt_q;
    op_d            = op_q;
    p_writereg_d    = p_writereg_q;
    p_memwrite_d    = p_memwrite_q;
    p_regaddress_d  = p_regaddress_q;
    p_address_d     = p_address_q;
    p_storedata_d   = p_storedata_q;
`endif
    if (accept_s) begin
      if (alu_hlt_s) begin
        state_d  = ST_HALT;
        halted_d = 1'b1;
      end
`ifdef P3_SERIAL_SHIFT_EN
      else if (start_serial_s) begin
        state_d        = ST_SHIFT;
        sh_d           = bus.alu2;
        cnt_d          = bus.shamt;
        op_d           = bus.opcode;
        p_writereg_d   = bus.writereg;
        p_memwrite_d   = bus.memwrite;
        p_regaddress_d = bus.regaddress;
        p_address_d    = bus.address;
        p_storedata_d  = bus.storedata;
      end
`endif
      else begin
        out_valid_d     = 1'b1;
        result_d        = alu_result_s;
        ex_writereg_d   = bus.writereg & ~alu_nowrite_s;
        ex_memwrite_d   = bus.memwrite;
        ex_regaddress_d = bus.regaddress;
        ex_address_d    = bus.address;
        ex_storedata_d  = bus.storedata;
        flags_d         = alu_flags_s;
      end
    end
`ifdef P3_SERIAL_SHIFT_EN
    // Last step is folded into the register edge so latency is 1+shamt
    else if (state_q == ST_SHIFT) begin
      if (cnt_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
        if (out_free_s) begin
          state_d         = ST_IDLE;
          out_valid_d     = 1'b1;
          result_d        = step_s[WIDTH-1:0];
          ex_writereg_d   = p_writereg_q;
          ex_memwrite_d   = p_memwrite_q;
          ex_regaddress_d = p_regaddress_q;
          ex_address_d    = p_address_q;
          ex_storedata_d  = p_storedata_q;
          flags_d         = {step_s[WIDTH-1], (step_s[WIDTH-1:0] == {WIDTH{1'b0}}),
                             step_s[WIDTH], 1'b0};
        end else begin
          state_d = ST_SHIFT;
        end
      end else begin
        sh_d  = step_s[WIDTH-1:0];
        cnt_d = cnt_q - {{(SHAMT_W-1){1'b0}}, 1'b1};
      end
    end
`endif
    else begin
      state_d = state_q;
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      out_valid_q     <= 1'b0;
      result_q        <= {WIDTH{1'b0}};
      ex_writereg_q   <= 1'b0;
      ex_memwrite_q   <= 2'b00;
      ex_regaddress_q <= 3'b000;
      ex_address_q    <= {WIDTH{1'b0}};
      ex_storedata_q  <= {WIDTH{1'b0}};
      flags_q         <= 4'b0000;
      halted_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      out_valid_q     <= out_valid_d;
      result_q        <= result_d;
      ex_writereg_q   <= ex_writereg_d;
      ex_memwrite_q   <= ex_memwrite_d;
      ex_regaddress_q <= ex_regaddress_d;
      ex_address_q    <= ex_address_d;
      ex_storedata_q  <= ex_storedata_d;
      flags_q         <= flags_d;
      halted_q        <= halted_d;
    end
  end

`ifdef P3_SERIAL_SHIFT_EN
  // Serial shifter working registers and the control held while shifting
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sh_q           <= {WIDTH{1'b0}};
      cnt_q          <= {SHAMT_W{1'b0}};
      op_q           <= 4'd0;
      p_writereg_q   <= 1'b0;
      p_memwrite_q   <= 2'b00;
      p_regaddress_q <= 3'b000;
      p_address_q    <= {WIDTH{1'b0}};
      p_storedata_q  <= {WIDTH{1'b0}};
    end else begin
      sh_q           <= sh_d;
      cnt_q          <= cnt_d;
      op_q           <= op_d;
      p_writereg_q   <= p_writereg_d;
      p_memwrite_q   <= p_memwrite_d;
      p_regaddress_q <= p_regaddress_d;
      p_address_q    <= p_address_d;
      p_storedata_q  <= p_storedata_d;
    end
  end
`endif

  assign bus.in_ready      = in_ready_s;
  assign bus.out_valid     = out_valid_q;
  assign bus.result        = result_q;
  assign bus.ex_writereg   = ex_writereg_q;
  assign bus.ex_memwrite   = ex_memwrite_q;
  assign bus.ex_regaddress = ex_regaddress_q;
  assign bus.ex_address    = ex_address_q;
  assign bus.ex_storedata  = ex_storedata_q;
  assign bus.flags         = flags_q;
  assign bus.halted        = halted_q;

endmodule
